// File: rtl/maint_pkg.sv
// Shared types and constants for the maintenance request generator.
package maint_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      REQ     = 2'd2,
      SERVICE = 2'd3
   } req_state_t;

   localparam logic [7:0] SERVED_MAX = 8'd255;

endpackage

// File: rtl/maint_usage_counter.sv
// Pausable usage counter with synchronous clear; tc flags the last count (INTERVAL-1).
module maint_usage_counter #(
   parameter int INTERVAL = 100,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          tc
);

   localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

   // clear wins over en so the terminal cycle lands on 0 rather than wrapping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == LAST);

endmodule

// File: rtl/maint_request_gen.sv
// Maintenance requester: counts run cycles, raises m every INTERVAL of them, waits for ack/done.
// Optional ack-timeout alarm is built when MAINT_TIMEOUT_EN is defined.
module maint_request_gen
   import maint_pkg::*;
#(
   parameter int INTERVAL = 100,
   parameter int CW       = 16,
   parameter int TIMEOUT  = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          ack,
   input  logic          done,
   output logic          m,
   output logic          busy,
   output logic [CW-1:0] usage,
   output logic [7:0]    served,
   output logic          alarm,
   output req_state_t    state
);

   if (INTERVAL < 2 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
      $error("maint_request_gen: INTERVAL must be >= 2 and TIMEOUT in 1..255");
   end

   logic cnt_clear;
   logic cnt_en;
   logic cnt_tc;

   maint_usage_counter #(
      .INTERVAL (INTERVAL),
      .CW       (CW)
   ) u_usage (
      .clk   (clk),
      .rst   (rst),
      .clear (cnt_clear),
      .en    (cnt_en),
      .count (usage),
      .tc    (cnt_tc)
   );

   // Usage only moves while idle or counting; it sits at 0 through request and service.
   always_comb begin
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      case (state)
         IDLE:    cnt_en = run;
         COUNT: begin
            cnt_clear = run & cnt_tc;
            cnt_en    = run & ~cnt_tc;
         end
         default: cnt_clear = 1'b1;
      endcase
   end

`ifdef MAINT_TIMEOUT_EN
   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
   logic [7:0] tmo;
`else
   assign alarm = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         m      <= 1'b0;
         busy   <= 1'b0;
         served <= '0;
`ifdef MAINT_TIMEOUT_EN
         tmo    <= '0;
         alarm  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (run) state <= COUNT;
            end
            COUNT: begin
               if (run && cnt_tc) begin
                  state <= REQ;
                  m     <= 1'b1;
                  busy  <= 1'b1;
`ifdef MAINT_TIMEOUT_EN
                  tmo   <= '0;
`endif
               end
            end
            REQ: begin
               if (ack) begin
                  state <= SERVICE;
                  m     <= 1'b0;
               end
`ifdef MAINT_TIMEOUT_EN
               // counter parks at the limit; alarm stays sticky until reset
               else if (tmo != TMO_LIMIT) begin
                  tmo <= tmo + 8'd1;
                  if (tmo + 8'd1 == TMO_LIMIT) alarm <= 1'b1;
               end
`endif
            end
            SERVICE: begin
               if (done) begin
                  busy  <= 1'b0;
                  state <= run ? COUNT : IDLE;
                  if (served != SERVED_MAX) served <= served + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_maint_request_gen.sv
// Bench for maint_request_gen: directed phases plus random traffic against a behavioural model.
// Define MAINT_TIMEOUT_EN for both bench and RTL to exercise the alarm.
module tb_maint_request_gen;
   import maint_pkg::*;

   localparam int INTERVAL = 10;
   localparam int CW       = 16;
   localparam int TIMEOUT  = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic          ack;
   logic          done;
   logic          m;
   logic          busy;
   logic [CW-1:0] usage;
   logic [7:0]    served;
   logic          alarm;
   req_state_t    state;

   maint_request_gen #(
      .INTERVAL (INTERVAL),
      .CW       (CW),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .ack    (ack),
      .done   (done),
      .m      (m),
      .busy   (busy),
      .usage  (usage),
      .served (served),
      .alarm  (alarm),
      .state  (state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [CW-1:0] exp_q[$];

   // ---------------- reference model ----------------
   // requesting: m high, waiting for ack; servicing: ack seen, waiting for done.
   int mod_usage;
   int mod_served;
   int mod_wait;
   bit mod_requesting;
   bit mod_servicing;
   bit mod_alarm;

   task automatic model_reset();
      mod_usage      = 0;
      mod_served     = 0;
      mod_wait       = 0;
      mod_requesting = 0;
      mod_servicing  = 0;
      mod_alarm      = 0;
   endtask

   task automatic model_step(input bit r, input bit a, input bit d);
      if (mod_requesting) begin
         if (a) begin
            mod_requesting = 0;
            mod_servicing  = 1;
         end else begin
            mod_wait++;
`ifdef MAINT_TIMEOUT_EN
            if (mod_wait >= TIMEOUT) mod_alarm = 1;
`endif
         end
      end else if (mod_servicing) begin
         if (d) begin
            mod_servicing = 0;
            mod_served    = (mod_served < 255) ? mod_served + 1 : 255;
         end
      end else if (r) begin
         if (mod_usage + 1 == INTERVAL) begin
            mod_usage      = 0;
            mod_requesting = 1;
            mod_wait       = 0;
         end else begin
            mod_usage++;
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".m"},      32'(m),      32'(mod_requesting));
      check({tag, ".busy"},   32'(busy),   32'(mod_requesting | mod_servicing));
      check({tag, ".usage"},  32'(usage),  32'(mod_usage));
      check({tag, ".served"}, 32'(served), 32'(mod_served));
      check({tag, ".alarm"},  32'(alarm),  32'(mod_alarm));
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input bit r, input bit a, input bit d, input string tag);
      run  = r;
      ack  = a;
      done = d;
      @(posedge clk);
      model_step(r, a, d);
      #1;
      compare_all(tag);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      compare_all("reset");
      check("reset.state", 32'(state), 32'(IDLE));
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_req(input string tag);
      int k = 0;
      while (!mod_requesting && k < 4 * INTERVAL) begin
         cycle(1'b1, 1'b0, 1'b0, tag);
         k++;
      end
      check({tag, ".req_reached"}, 32'(m), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst  = 1'b0;
      run  = 1'b0;
      ack  = 1'b0;
      done = 1'b0;
      do_reset();

      // run held high: usage 1..9 then 0 with m rising on the 10th edge
      for (int i = 1; i < INTERVAL; i++) exp_q.push_back(CW'(i));
      exp_q.push_back('0);
      for (int i = 0; i < INTERVAL; i++) begin
         cycle(1'b1, 1'b0, 1'b0, "run_held");
         check("run_held.usage_seq", 32'(usage), 32'(exp_q.pop_front()));
         if (i < INTERVAL - 1) check("run_held.m_low", 32'(m), 32'd0);
      end
      check("run_held.m_rise", 32'(m), 32'd1);

      // m high three cycles, ack, then done two cycles later
      cycle(1'b0, 1'b0, 1'b0, "req_hold");
      cycle(1'b0, 1'b0, 1'b0, "req_hold");
      check("req_hold.m_still", 32'(m), 32'd1);
      cycle(1'b0, 1'b1, 1'b0, "req_ack");
      check("req_ack.m_drop", 32'(m), 32'd0);
      check("req_ack.busy", 32'(busy), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, "service");
      cycle(1'b0, 1'b0, 1'b1, "service_done");
      check("service_done.served", 32'(served), 32'd1);
      check("service_done.busy", 32'(busy), 32'd0);

      // alternating run: usage pauses on low cycles
      for (int i = 0; i < 2 * INTERVAL; i++)
         cycle(i % 2 == 0, 1'b0, 1'b0, "toggle");
      check("toggle.m", 32'(m), 32'd1);
      cycle(1'b0, 1'b1, 1'b0, "toggle_ack");
      cycle(1'b1, 1'b0, 1'b1, "toggle_done");

      // done in REQ is ignored; ack+done together takes only ack
      wait_req("ign");
      cycle(1'b0, 1'b0, 1'b1, "ign_done_in_req");
      check("ign_done_in_req.served", 32'(served), 32'd2);
      cycle(1'b0, 1'b1, 1'b1, "ign_ack_done");
      check("ign_ack_done.served", 32'(served), 32'd2);
      check("ign_ack_done.busy", 32'(busy), 32'd1);
      cycle(1'b0, 1'b0, 1'b1, "ign_done");
      check("ign_done.served", 32'(served), 32'd3);

      // random traffic with occasional asynchronous mid-cycle reset
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, "rand");
         if ($urandom_range(0, 149) == 0) begin
            #2;
            rst = 1'b0;
            #1;
            model_reset();
            compare_all("async_rst");
            check("async_rst.state", 32'(state), 32'(IDLE));
            @(negedge clk);
            rst = 1'b1;
         end
      end

      // served saturation
      do_reset();
      for (int i = 0; i < 256; i++) begin
         wait_req("sat");
         cycle(1'b0, 1'b1, 1'b0, "sat_ack");
         cycle(1'b0, 1'b0, 1'b1, "sat_done");
      end
      check("sat.served_max", 32'(served), 32'd255);

      // ack timeout
      do_reset();
      wait_req("tmo");
      for (int i = 0; i < TIMEOUT + 2; i++) cycle(1'b0, 1'b0, 1'b0, "tmo_wait");
      check("tmo.m_held", 32'(m), 32'd1);
`ifdef MAINT_TIMEOUT_EN
      check("tmo.alarm_set", 32'(alarm), 32'd1);
`else
      check("tmo.alarm_off", 32'(alarm), 32'd0);
`endif
      cycle(1'b0, 1'b1, 1'b0, "tmo_ack");
      cycle(1'b0, 1'b0, 1'b1, "tmo_done");
      check("tmo_done.served", 32'(served), 32'd1);
      do_reset();
      check("tmo_reset.alarm", 32'(alarm), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
